qspi_mc: RTL

Parametrised multi-device QSPI line-transfer engine. Moves one cache line between external memory and the icache/dcache over a 4-bit QPI bus.
Successor to the fixed two-device qspi block, with these generalisations:
- NCS chip selects instead of two.
- Configurable address width and per-device-class dummy cycles.
- Line length set by parameter.
- Explicit done/error handshake.
- Write protection for the flash device.

---
 rtl/qspi_mc.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/qspi_mc.sv
// Multi-device QSPI line-transfer engine: moves one cache line between external
// flash/SRAM and the icache/dcache over a 4-bit bus, one nibble per SCK period.
module qspi_mc #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int NCS         = 2,
  parameter int ADDR_BYTES  = 3,
  parameter int FLASH_DUMMY = 4,
  parameter int SRAM_DUMMY  = 2,
  parameter int CS_HIGH     = 2,
  localparam int SW  = (NCS > 1) ? $clog2(NCS) : 1,
  localparam int OFF = $clog2(LINE_LENGTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              i_d,
  input  logic              write,
  input  logic [SW-1:0]     cs_sel,
  input  logic [PA-OFF-1:0] paddr,
  input  logic [3:0]        dwrite,
  output logic [3:0]        rnib,
  output logic              wstrobe_i,
  output logic              wstrobe_d,
  output logic              rstrobe_d,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic              sck,
  output logic [NCS-1:0]    cs,
  input  logic [3:0]        uio_in,
  output logic [3:0]        uio_out,
  output logic [3:0]        uio_oe
);

  localparam int AW    = ADDR_BYTES * 8;
  localparam int DLEN  = 2 * LINE_LENGTH;
  localparam int NMAX0 = (DLEN > 2 * ADDR_BYTES) ? DLEN : 2 * ADDR_BYTES;
  localparam int NMAX1 = (NMAX0 > FLASH_DUMMY) ? NMAX0 : FLASH_DUMMY;
  localparam int NMAX  = (NMAX1 > SRAM_DUMMY) ? NMAX1 : SRAM_DUMMY;
  localparam int CW    = $clog2(NMAX + 1);
  localparam int GW    = $clog2(CS_HIGH + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
  } state_t;

  state_t          state_q;
  logic            phase_q;      // 0 = SCK low phase, 1 = SCK high phase
  logic [CW-1:0]   nib_q;
  logic [CW-1:0]   dummy_q;
  logic [GW-1:0]   gap_q;
  logic            blocked_q;
  logic            i_d_q;
  logic            write_q;
  logic [AW+7:0]   sr_q;

  logic [CW-1:0]   state_len;
  logic            nib_last;
  state_t          adv_state;
  state_t          nxt_state;
  logic            req_bad;
  logic            gap_ok;
  logic [7:0]      cmd_byte;
  logic [PA-1:0]   addr_full;
  logic [AW-1:0]   addr_bytes;
  logic [CW-1:0]   req_dummy;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_len = '0;
    adv_state = S_IDLE;
    case (state_q)
      S_CMD: begin
        state_len = CW'(2);
        adv_state = S_ADDR;
      end
      S_ADDR: begin
        state_len = CW'(2 * ADDR_BYTES);
        adv_state = (write_q || dummy_q == '0) ? S_DATA : S_DUMMY;
      end
      S_DUMMY: begin
        state_len = dummy_q;
        adv_state = S_DATA;
      end
      S_DATA: begin
        state_len = CW'(DLEN);
        adv_state = S_GAP;
      end
      default: ;
    endcase
  end

  assign nib_last  = (nib_q == state_len - CW'(1));
  assign nxt_state = nib_last ? adv_state : state_q;

  assign req_bad    = (write && cs_sel == '0) || (int'(cs_sel) >= NCS);
  assign gap_ok     = (int'(gap_q) >= CS_HIGH);
  assign cmd_byte   = (cs_sel == '0) ? 8'hEB : (write ? 8'h02 : 8'h03);
  assign addr_full  = {paddr, {OFF{1'b0}}};
  assign addr_bytes = AW'(addr_full);
  assign req_dummy  = write ? '0 : ((cs_sel == '0) ? CW'(FLASH_DUMMY) : CW'(SRAM_DUMMY));

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      nib_q     <= '0;
      dummy_q   <= '0;
      gap_q     <= GW'(CS_HIGH);
      blocked_q <= 1'b0;
      i_d_q     <= 1'b0;
      write_q   <= 1'b0;
      sr_q      <= '0;
      rnib      <= 4'h0;
      wstrobe_i <= 1'b0;
      wstrobe_d <= 1'b0;
      rstrobe_d <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      sck       <= 1'b0;
      cs        <= '1;
      uio_out   <= 4'h0;
      uio_oe    <= 4'h0;
    end else begin
      wstrobe_i <= 1'b0;
      wstrobe_d <= 1'b0;
      rstrobe_d <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      if (!req) blocked_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req && !blocked_q && gap_ok) begin
            if (req_bad) begin
              // One error pulse per request; requester must drop req to retry.
              error     <= 1'b1;
              blocked_q <= 1'b1;
            end else begin
              state_q <= S_CMD;
              phase_q <= 1'b0;
              nib_q   <= '0;
              i_d_q   <= i_d;
              write_q <= write;
              dummy_q <= req_dummy;
              sr_q    <= {cmd_byte[3:0], addr_bytes, 4'h0};
              uio_out <= cmd_byte[7:4];
              uio_oe  <= 4'hF;
              cs      <= ~(NCS'(1) << cs_sel);
              busy    <= 1'b1;
            end
          end
        end

        S_GAP: begin
          gap_q <= gap_q + GW'(1);
          if (int'(gap_q) + 1 >= CS_HIGH) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            sck     <= 1'b1;
            if (state_q == S_DATA && write_q) uio_out <= dwrite;
          end else begin
            phase_q <= 1'b0;
            sck     <= 1'b0;
            if (state_q == S_DATA && !write_q) begin
              rnib      <= uio_in;
              wstrobe_i <= i_d_q;
              wstrobe_d <= !i_d_q;
            end
            nib_q   <= nib_last ? '0 : nib_q + CW'(1);
            state_q <= nxt_state;
            // Set up the outputs of the coming low phase.
            case (nxt_state)
              S_CMD, S_ADDR: begin
                uio_out <= sr_q[AW+7 -: 4];
                sr_q    <= sr_q << 4;
                uio_oe  <= 4'hF;
              end
              S_DUMMY: uio_oe <= 4'h0;
              S_DATA: begin
                uio_oe    <= write_q ? 4'hF : 4'h0;
                rstrobe_d <= write_q;
              end
              default: begin
                cs     <= '1;
                uio_oe <= 4'h0;
                done   <= 1'b1;
                gap_q  <= '0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
